// File: rtl/laser_host.sv
// laser_host - host-side driver for the LASER circle-cover core.
//
// Holds one frame of NPTS points loaded by the system, streams them on X/Y
// during the core's DONE-framed input window, and captures the returned
// circle centres. With LASER_HOST_SCORE_EN defined, the answer is also scored
// as the number of points covered by either circle. Without it, there is no
// SCORE state, res_score is tied to 0, and res_valid pulses in the cycle
// right after capture.
//
// Parameters: NPTS (points per frame), R2 (squared radius),
//             TMO_W (watchdog width, fires 2**TMO_W-1 cycles into WAIT)
// Ports:
//   CLK, RST            clock (rising edge), async active-high reset
//   ld_we/ld_addr/ld_x/ld_y  frame buffer write (IDLE only, addr < NPTS)
//   start               arm a frame (IDLE only)
//   busy                high in every state except IDLE
//   X, Y                registered point stream to the core
//   DONE, C1X..C2Y      core frame strobe and result
//   res_valid           1-cycle pulse, results valid
//   res_c1x..res_c2y    captured circle centres
//   res_score           covered-point count
//   timeout             1-cycle pulse, watchdog fired in WAIT
//
// state  | meaning
// IDLE   | accept buffer writes, X=Y=0, wait for start
// ARM    | wait for DONE to mark the start of the core's input window
// STREAM | drive pt[0..NPTS-1], one per cycle
// WAIT   | wait for DONE carrying this frame's answer, watchdog running
// SCORE  | count covered points, one per cycle (LASER_HOST_SCORE_EN only)

module laser_host #(
  parameter int NPTS  = 40,
  parameter int R2    = 16,
  parameter int TMO_W = 12
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ld_we,
  input  logic [5:0] ld_addr,
  input  logic [3:0] ld_x,
  input  logic [3:0] ld_y,
  input  logic       start,
  output logic       busy,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic       res_valid,
  output logic [3:0] res_c1x,
  output logic [3:0] res_c1y,
  output logic [3:0] res_c2x,
  output logic [3:0] res_c2y,
  output logic [5:0] res_score,
  output logic       timeout
);

  localparam logic [5:0] NPTS6 = 6'(NPTS);
  // WAIT lasts 2**TMO_W-1 cycles: down-counter loaded with 2**TMO_W-2,
  // timeout fires on the edge leaving terminal count 0.
  localparam logic [TMO_W-1:0] WD_LOAD = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_STREAM,
    S_WAIT
`ifdef LASER_HOST_SCORE_EN
    , S_SCORE
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [TMO_W-1:0] wd_q, wd_d;
  logic [3:0]       x_d, y_d;
  logic             timeout_d, res_valid_d, capture;

  logic [3:0] pt_x [NPTS];
  logic [3:0] pt_y [NPTS];

  // Frame buffer is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (ld_we && state_q == S_IDLE && ld_addr < NPTS6) begin
      pt_x[ld_addr] <= ld_x;
      pt_y[ld_addr] <= ld_y;
    end
  end

  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wd_d        = wd_q;
    x_d         = 4'd0;
    y_d         = 4'd0;
    timeout_d   = 1'b0;
    res_valid_d = 1'b0;
    capture     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ARM;
      end
      S_ARM: begin
        // The result carried by this DONE belongs to a dummy frame.
        if (DONE) begin
          x_d     = pt_x[0];
          y_d     = pt_y[0];
          idx_d   = 6'd1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (DONE) begin
          state_d = S_ARM;
        end else if (idx_q == NPTS6) begin
          wd_d    = WD_LOAD;
          state_d = S_WAIT;
        end else begin
          x_d   = pt_x[idx_q];
          y_d   = pt_y[idx_q];
          idx_d = idx_q + 6'd1;
        end
      end
      S_WAIT: begin
        if (DONE) begin
          capture = 1'b1;
`ifdef LASER_HOST_SCORE_EN
          idx_d   = 6'd0;
          state_d = S_SCORE;
`else
          res_valid_d = 1'b1;
          state_d     = S_IDLE;
`endif
        end else if (wd_q == '0) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q - TMO_W'(1);
        end
      end
`ifdef LASER_HOST_SCORE_EN
      S_SCORE: begin
        // NPTS+1 cycles: one per point plus one to drain the hit register.
        if (idx_q == NPTS6) begin
          res_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      idx_q     <= 6'd0;
      wd_q      <= '0;
      X         <= 4'd0;
      Y         <= 4'd0;
      timeout   <= 1'b0;
      res_valid <= 1'b0;
      res_c1x   <= 4'd0;
      res_c1y   <= 4'd0;
      res_c2x   <= 4'd0;
      res_c2y   <= 4'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wd_q      <= wd_d;
      X         <= x_d;
      Y         <= y_d;
      timeout   <= timeout_d;
      res_valid <= res_valid_d;
      if (capture) begin
        res_c1x <= C1X;
        res_c1y <= C1Y;
        res_c2x <= C2X;
        res_c2y <= C2Y;
      end
    end
  end

`ifdef LASER_HOST_SCORE_EN
  function automatic logic hit(input logic [3:0] px, input logic [3:0] py,
                               input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [7:0] dx8, dy8, sx, sy;
    logic [8:0] d2;
    dx  = (px >= cx) ? px - cx : cx - px;
    dy  = (py >= cy) ? py - cy : cy - py;
    dx8 = {4'd0, dx};
    dy8 = {4'd0, dy};
    sx  = dx8 * dx8;
    sy  = dy8 * dy8;
    d2  = {1'b0, sx} + {1'b0, sy};
    return (d2 <= 9'(R2));
  endfunction

  logic       cov_q, cov_d;
  logic [5:0] cnt_q, cnt_sum, sidx, res_score_q;

  always_comb begin
    sidx    = (idx_q < NPTS6) ? idx_q : 6'd0;
    cov_d   = hit(pt_x[sidx], pt_y[sidx], res_c1x, res_c1y) |
              hit(pt_x[sidx], pt_y[sidx], res_c2x, res_c2y);
    cnt_sum = cnt_q + {5'd0, cov_q};
    if (cnt_sum > NPTS6) cnt_sum = NPTS6;
  end

  // cov_q holds the hit for pt[idx-1]; the count starts fresh at idx 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cov_q       <= 1'b0;
      cnt_q       <= 6'd0;
      res_score_q <= 6'd0;
    end else if (state_q == S_SCORE) begin
      cov_q <= cov_d;
      cnt_q <= (idx_q == 6'd0) ? 6'd0 : cnt_sum;
      if (idx_q == NPTS6) res_score_q <= cnt_sum;
    end
  end

  assign res_score = res_score_q;
`else
  assign res_score = 6'd0;
`endif

endmodule

// File: tb/tb_laser_host.sv
module tb_laser_host;

  localparam int NPTS = 40;
`ifdef LASER_HOST_SCORE_EN
  localparam int LAT   = NPTS + 1;
  localparam int SC_EN = 1;
`else
  localparam int LAT   = 0;
  localparam int SC_EN = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       ld_we;
  logic [5:0] ld_addr;
  logic [3:0] ld_x, ld_y;
  logic       start;
  logic       busy;
  logic [3:0] X, Y;
  logic       DONE;
  logic [3:0] C1X, C1Y, C2X, C2Y;
  logic       res_valid;
  logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
  logic [5:0] res_score;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_x [NPTS];
  logic [3:0] exp_y [NPTS];

  laser_host #(.NPTS(NPTS), .R2(16), .TMO_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_x(ld_x), .ld_y(ld_y),
    .start(start), .busy(busy), .X(X), .Y(Y), .DONE(DONE),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .res_valid(res_valid),
    .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
    .res_score(res_score), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_pt(input int i, input logic [3:0] x, input logic [3:0] y, input logic st);
    exp_x[i] = x;
    exp_y[i] = y;
    ld_we    = 1'b1;
    ld_addr  = 6'(i);
    ld_x     = x;
    ld_y     = y;
    start    = st;
    step();
    ld_we    = 1'b0;
    start    = 1'b0;
  endtask

  // Called in ARM; returns at the first WAIT cycle.
  task automatic arm_and_stream();
    chk("busy_arm", busy, 1);
    ld_we = 1'b1; ld_addr = 6'd0; ld_x = 4'd9; ld_y = 4'd9;
    step();
    ld_we = 1'b0;
    chk("x_arm", X, 0);
    DONE = 1'b1;
    step();
    DONE = 1'b0;
    for (int k = 0; k < NPTS; k++) begin
      chk($sformatf("x_pt%0d", k), X, exp_x[k]);
      chk($sformatf("y_pt%0d", k), Y, exp_y[k]);
      step();
    end
    chk("x_wait", X, 0);
    chk("y_wait", Y, 0);
    chk("busy_wait", busy, 1);
  endtask

  task automatic capture(input logic [3:0] c1x, input logic [3:0] c1y,
                         input logic [3:0] c2x, input logic [3:0] c2y, input int score);
    int cyc;
    repeat (3) step();
    C1X = c1x; C1Y = c1y; C2X = c2x; C2Y = c2y;
    DONE = 1'b1;
    step();
    DONE = 1'b0;
    C1X = 4'hF; C1Y = 4'hF; C2X = 4'hF; C2Y = 4'hF;
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    chk("res_valid_lat", cyc, LAT);
    chk("res_c1x", res_c1x, c1x);
    chk("res_c1y", res_c1y, c1y);
    chk("res_c2x", res_c2x, c2x);
    chk("res_c2y", res_c2y, c2y);
    chk("res_score", res_score, score);
    chk("busy_done", busy, 0);
    step();
    chk("res_valid_pulse", res_valid, 0);
  endtask

  initial begin
    int cyc;
    RST = 1'b1; DONE = 1'b1; ld_we = 1'b0; ld_addr = 6'd0; ld_x = 4'd0; ld_y = 4'd0;
    start = 1'b0; C1X = 4'd0; C1Y = 4'd0; C2X = 4'd0; C2Y = 4'd0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_x", X, 0);
    chk("rst_y", Y, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_score", res_score, 0);
    RST = 1'b0; DONE = 1'b0;
    step();

    // Frame 1: (i%16, i%16); last write shares the cycle with start.
    for (int i = 0; i < NPTS - 1; i++) load_pt(i, 4'(i % 16), 4'(i % 16), 1'b0);
    load_pt(NPTS - 1, 4'((NPTS - 1) % 16), 4'((NPTS - 1) % 16), 1'b1);
    arm_and_stream();
    capture(4'd0, 4'd0, 4'd15, 4'd15, 15 * SC_EN);

    // Frame 2: every point at (3,3).
    for (int i = 0; i < NPTS; i++) load_pt(i, 4'd3, 4'd3, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    arm_and_stream();
    capture(4'd3, 4'd3, 4'd12, 4'd12, 40 * SC_EN);

    // Frame 3: 20 at (0,0), 20 at (15,15).
    for (int i = 0; i < NPTS; i++)
      load_pt(i, (i < 20) ? 4'd0 : 4'd15, (i < 20) ? 4'd0 : 4'd15, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    arm_and_stream();
    capture(4'd0, 4'd0, 4'd4, 4'd4, 20 * SC_EN);

    // Watchdog: no DONE after the stream.
    start = 1'b1; step(); start = 1'b0;
    arm_and_stream();
    cyc = 0;
    while (timeout !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("timeout_lat", cyc, 15);
    chk("timeout_busy", busy, 0);
    chk("timeout_res_kept", res_c2x, 4);
    chk("timeout_no_valid", res_valid, 0);
    step();
    chk("timeout_pulse", timeout, 0);

    // Protocol error: DONE during stream cycle 10.
    for (int i = 0; i < NPTS; i++) load_pt(i, 4'(i % 16), 4'(15 - (i % 16)), 1'b0);
    start = 1'b1; step(); start = 1'b0;
    DONE = 1'b1; step(); DONE = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("abort_x%0d", k), X, exp_x[k]);
      if (k == 10) DONE = 1'b1;
      step();
    end
    DONE = 1'b0;
    chk("abort_x0", X, 0);
    chk("abort_busy", busy, 1);
    step();
    chk("abort_arm_x", X, 0);
    DONE = 1'b1; step(); DONE = 1'b0;
    chk("restart_x0", X, exp_x[0]);
    chk("restart_y0", Y, exp_y[0]);
    step();
    chk("restart_x1", X, exp_x[1]);
    chk("restart_y1", Y, exp_y[1]);

    // Asynchronous reset mid-stream; buffer survives.
    #2;
    RST = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_x", X, 0);
    chk("arst_y", Y, 0);
    chk("arst_res_c2x", res_c2x, 0);
    chk("arst_score", res_score, 0);
    step();
    RST = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    arm_and_stream();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
